// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad emulator: key code fields,
// emulator FSM states and the idle (released) column pattern.
package keypad_pkg;

    typedef logic [3:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic [1:0] key_row(input key_t k);
        return k[3:2];
    endfunction

    function automatic logic [1:0] key_col(input key_t k);
        return k[1:0];
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keypad_emulator_sync_fifo.sv
// Small first-word-fall-through FIFO: o_data always shows the head entry,
// so the consumer can pop and capture in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 row-scan keypad: replays queued key codes as
// physical presses (bounce, hold, release bounce, gap) on the column lines.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int BOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES    = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       pressed,
    output logic [3:0] pressed_key,
    output logic       busy
);
    localparam int MAXP = max3(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES);
    localparam int CW   = (MAXP > 0) ? $clog2(MAXP + 1) : 1;

    state_t      r_state;
    state_t      w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic        r_pressed;
    logic        w_pressed_next;
    key_t        r_pressed_key;
    key_t        w_key_next;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    key_t        w_head;
    logic [3:0]  w_col_sel;

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (key_valid),
        .i_data  (key_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_pressed     <= 1'b0;
            r_pressed_key <= '0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_pressed     <= w_pressed_next;
            r_pressed_key <= w_key_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_pressed_next = r_pressed;
        w_key_next     = r_pressed_key;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_key_next     = w_head;
                    w_pressed_next = 1'b1;
                    if (BOUNCE_CYCLES > 0) begin
                        w_state_next = ST_BOUNCE_IN;
                        w_count_next = CW'(BOUNCE_CYCLES - 1);
                    end else begin
                        w_state_next = ST_HOLD;
                        w_count_next = CW'(HOLD_CYCLES - 1);
                    end
                end
            end
            ST_BOUNCE_IN: begin
                if (r_count == '0) begin
                    w_state_next   = ST_HOLD;
                    w_pressed_next = 1'b1;
                    w_count_next   = CW'(HOLD_CYCLES - 1);
                end else begin
                    w_pressed_next = !r_pressed;
                    w_count_next   = r_count - CW'(1);
                end
            end
            ST_HOLD: begin
                w_pressed_next = 1'b1;
                if (r_count == '0) begin
                    w_pressed_next = 1'b0;
                    if (BOUNCE_CYCLES > 0) begin
                        w_state_next = ST_BOUNCE_OUT;
                        w_count_next = CW'(BOUNCE_CYCLES - 1);
                    end else begin
                        w_state_next = ST_GAP;
                        w_count_next = CW'(GAP_CYCLES - 1);
                    end
                end else begin
                    w_count_next = r_count - CW'(1);
                end
            end
            ST_BOUNCE_OUT: begin
                if (r_count == '0) begin
                    w_state_next   = ST_GAP;
                    w_pressed_next = 1'b0;
                    w_count_next   = CW'(GAP_CYCLES - 1);
                end else begin
                    w_pressed_next = !r_pressed;
                    w_count_next   = r_count - CW'(1);
                end
            end
            ST_GAP: begin
                w_pressed_next = 1'b0;
                if (r_count == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_next = r_count - CW'(1);
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_pressed_next = 1'b0;
            end
        endcase
    end

    // A column is pulled low only while the contact is closed and its row is driven.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign w_col_sel[gi] = r_pressed
                            && (key_col(r_pressed_key) == 2'(gi))
                            && !rows[key_row(r_pressed_key)];
    end

    always_comb begin
        cols        = ROWS_IDLE & ~w_col_sel;
        busy        = (r_state != ST_IDLE) || !w_empty;
        key_ready   = !w_full;
        pressed     = r_pressed;
        pressed_key = r_pressed_key;
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench: one clean-edge instance (no bounce) and one bouncing instance.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic [3:0] key_in0 = 4'h0;
    logic       key_valid0 = 1'b0;
    logic [3:0] rows0 = 4'hF;
    logic       key_ready0;
    logic [3:0] cols0;
    logic       pressed0;
    logic [3:0] pressed_key0;
    logic       busy0;

    logic [3:0] key_in1 = 4'h0;
    logic       key_valid1 = 1'b0;
    logic [3:0] rows1 = 4'hF;
    logic       key_ready1;
    logic [3:0] cols1;
    logic       pressed1;
    logic [3:0] pressed_key1;
    logic       busy1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sweep [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exp4  [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    logic [3:0] exp6  [6] = '{4'h3, 4'h7, 4'h8, 4'h9, 4'hC, 4'hD};

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES   (16),
        .BOUNCE_CYCLES (0),
        .GAP_CYCLES    (8),
        .FIFO_DEPTH    (4)
    ) u_dut_clean (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in0),
        .key_valid   (key_valid0),
        .key_ready   (key_ready0),
        .rows        (rows0),
        .cols        (cols0),
        .pressed     (pressed0),
        .pressed_key (pressed_key0),
        .busy        (busy0)
    );

    keypad_emulator #(
        .HOLD_CYCLES   (16),
        .BOUNCE_CYCLES (4),
        .GAP_CYCLES    (8),
        .FIFO_DEPTH    (4)
    ) u_dut_bnc (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in1),
        .key_valid   (key_valid1),
        .key_ready   (key_ready1),
        .rows        (rows1),
        .cols        (cols1),
        .pressed     (pressed1),
        .pressed_key (pressed_key1),
        .busy        (busy1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        while (busy0 && n < 200) begin
            tick();
            n++;
        end
        check_val("idle_timeout", 32'(busy0), 32'(0));
    endtask

    initial begin
        logic [3:0] exp_cols;
        logic       e;
        logic       prev;
        int         n_press;
        int         n_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        for (int r = 0; r < 16; r++) begin
            rows0 = 4'(r);
            rows1 = 4'(r);
            #1;
            check_val("rst_cols0", 32'(cols0), 32'(4'b1111));
            check_val("rst_cols1", 32'(cols1), 32'(4'b1111));
        end
        check_val("rst_ready0", 32'(key_ready0), 32'(1));
        check_val("rst_ready1", 32'(key_ready1), 32'(1));
        check_val("rst_busy0", 32'(busy0), 32'(0));
        check_val("rst_busy1", 32'(busy1), 32'(0));
        check_val("rst_pressed0", 32'(pressed0), 32'(0));
        check_val("rst_pkey0", 32'(pressed_key0), 32'(0));
        rows0 = 4'hF;
        rows1 = 4'hF;

        // Clean press of key 0110 (row 1, col 2) under a row sweep
        key_in0 = 4'b0110;
        key_valid0 = 1'b1;
        tick();
        key_valid0 = 1'b0;
        $display("push key %h (clean)", 4'b0110);
        for (int j = 0; j < 20; j++) begin
            rows0 = sweep[j % 4];
            #1;
            exp_cols = (j >= 1 && j <= 16 && rows0 == 4'b1101) ? 4'b1011 : 4'b1111;
            check_val($sformatf("t2_cols_j%0d", j), 32'(cols0), 32'(exp_cols));
            if (j == 1) check_val("t2_pkey", 32'(pressed_key0), 32'(4'b0110));
            tick();
        end
        rows0 = 4'hF;
        wait_idle0();

        // Bouncing press of key 0000 with row 0 held low
        key_in1 = 4'b0000;
        key_valid1 = 1'b1;
        rows1 = 4'b1110;
        tick();
        key_valid1 = 1'b0;
        $display("push key %h (bounce)", 4'b0000);
        for (int j = 1; j <= 33; j++) begin
            tick();
            if (j <= 4)       e = (j % 2 == 0);
            else if (j <= 20) e = 1'b0;
            else if (j <= 24) e = (j % 2 == 1);
            else              e = 1'b1;
            check_val($sformatf("t3_cols_j%0d", j), 32'(cols1), 32'({3'b111, e}));
            if (j == 32) check_val("t3_busy_gap", 32'(busy1), 32'(1));
            if (j == 33) check_val("t3_busy_idle", 32'(busy1), 32'(0));
        end
        rows1 = 4'hF;

        // Five back-to-back pushes, sixth attempt against a full FIFO
        prev = pressed0;
        n_press = 0;
        for (int j = 0; j <= 135; j++) begin
            if (pressed0 && !prev) begin
                $display("press key %h", pressed_key0);
                if (n_press < 5) check_val($sformatf("t4_order%0d", n_press), 32'(pressed_key0), 32'(exp4[n_press]));
                n_press++;
            end
            prev = pressed0;
            if (j == 5 || j == 6 || j == 26) check_val($sformatf("t4_ready_j%0d", j), 32'(key_ready0), 32'(0));
            if (j == 27)  check_val("t4_ready_j27", 32'(key_ready0), 32'(1));
            if (j == 125) check_val("t4_busy_j125", 32'(busy0), 32'(1));
            if (j == 126) check_val("t4_busy_j126", 32'(busy0), 32'(0));
            if (j <= 4) begin
                key_in0 = 4'(j + 1);
                key_valid0 = 1'b1;
            end else if (j == 5) begin
                key_in0 = 4'h9;
                key_valid0 = 1'b1;
            end else begin
                key_valid0 = 1'b0;
            end
            tick();
        end
        check_val("t4_press_count", 32'(n_press), 32'(5));
        wait_idle0();

        // Reset in the middle of the hold of key 1111, with another key queued
        key_in0 = 4'b1111;
        key_valid0 = 1'b1;
        tick();
        key_in0 = 4'b1010;
        tick();
        key_valid0 = 1'b0;
        rows0 = 4'b0111;
        repeat (4) tick();
        check_val("t5_cols_hold", 32'(cols0), 32'(4'b0111));
        check_val("t5_pressed_hold", 32'(pressed0), 32'(1));
        reset = 1'b0;
        #1;
        check_val("t5_cols_rst", 32'(cols0), 32'(4'b1111));
        check_val("t5_pressed_rst", 32'(pressed0), 32'(0));
        check_val("t5_busy_rst", 32'(busy0), 32'(0));
        check_val("t5_ready_rst", 32'(key_ready0), 32'(1));
        repeat (2) tick();
        reset = 1'b1;
        n_seen = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (pressed0 || busy0 || cols0 != 4'b1111) n_seen++;
        end
        check_val("t5_no_replay", 32'(n_seen), 32'(0));
        rows0 = 4'hF;

        // Push while the FSM pops, with a partially filled FIFO
        prev = pressed0;
        n_press = 0;
        for (int j = 0; j <= 160; j++) begin
            if (pressed0 && !prev) begin
                $display("press key %h", pressed_key0);
                if (n_press < 6) check_val($sformatf("t6_order%0d", n_press), 32'(pressed_key0), 32'(exp6[n_press]));
                n_press++;
            end
            prev = pressed0;
            if (j == 2) begin
                check_val("t6_ready_j2", 32'(key_ready0), 32'(1));
                check_val("t6_busy_j2", 32'(busy0), 32'(1));
            end
            if (j == 29 || j == 52) check_val($sformatf("t6_ready_j%0d", j), 32'(key_ready0), 32'(1));
            if (j == 30 || j == 51) check_val($sformatf("t6_ready_j%0d", j), 32'(key_ready0), 32'(0));
            if (j == 150) check_val("t6_busy_j150", 32'(busy0), 32'(1));
            if (j == 151) check_val("t6_busy_j151", 32'(busy0), 32'(0));
            key_valid0 = 1'b1;
            case (j)
                0:       key_in0 = 4'h3;
                1:       key_in0 = 4'h7;
                26:      key_in0 = 4'h8;
                27:      key_in0 = 4'h9;
                28:      key_in0 = 4'hC;
                29:      key_in0 = 4'hD;
                default: key_valid0 = 1'b0;
            endcase
            tick();
        end
        check_val("t6_press_count", 32'(n_press), 32'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
